// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the edge-capturing PIO slave: register word addresses
// and capture edge selection.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_edge_if.sv
// Avalon-MM slave bus of the PIO: word address, select, active-low write
// strobe and 32-bit data in both directions.
interface soc_system_pio_edge_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/soc_system_pio_sync.sv
// Multi-flop input synchroniser followed by a previous-sample flop and a
// per-bit edge detector selected by EDGE_TYPE.
module soc_system_pio_sync
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] sync_in,
    output logic [DATA_WIDTH-1:0] edge_pulse
);

    logic [DATA_WIDTH-1:0] stage_p [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_in;

    // Synchroniser chain; prev_in trails sync_in by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage_p[i] <= '0;
            prev_in <= '0;
        end else begin
            stage_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) stage_p[i] <= stage_p[i-1];
            prev_in <= stage_p[SYNC_STAGES-1];
        end
    end

    assign sync_in = stage_p[SYNC_STAGES-1];

    always_comb begin
        edge_pulse = sync_in & ~prev_in;
        if (EDGE_TYPE == EDGE_FALL)
            edge_pulse = ~sync_in & prev_in;
        else if (EDGE_TYPE == EDGE_ANY)
            edge_pulse = sync_in ^ prev_in;
    end

endmodule

// File: rtl/soc_system_pio_edge.sv
// Avalon-MM GPIO slave: output/direction registers, synchronised inputs with
// write-1-to-clear edge capture, and a maskable level interrupt.
module soc_system_pio_edge
    import soc_system_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    EDGE_TYPE   = EDGE_RISE,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    soc_system_pio_edge_if.slave      bus,
    input  logic [DATA_WIDTH-1:0]     in_port,
    output logic [DATA_WIDTH-1:0]     out_port,
    output logic [DATA_WIDTH-1:0]     out_oe,
    output logic                      irq
);

    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] edge_pulse;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edge_capture;
    logic [DATA_WIDTH-1:0] capture_next;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic                  wr_en;
    logic                  unused_wdata;

    function automatic logic [31:0] zero_ext(input logic [DATA_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[DATA_WIDTH-1:0] = v;
        return r;
    endfunction

    soc_system_pio_sync #(
        .DATA_WIDTH  (DATA_WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_in    (sync_in),
        .edge_pulse (edge_pulse)
    );

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wr_bits      = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // A new edge wins over a simultaneous write-1-to-clear on the same bit
    always_comb begin
        capture_next = edge_capture;
        if (wr_en && bus.address == ADDR_EDGE)
            capture_next = edge_capture & ~wr_bits;
        capture_next = capture_next | edge_pulse;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            out_port     <= RESET_OUT;
            out_oe       <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            // Read latency is fixed at one cycle, independent of chipselect
            case (bus.address)
                ADDR_DATA: bus.readdata <= zero_ext(sync_in);
                ADDR_DIR:  bus.readdata <= zero_ext(out_oe);
                ADDR_MASK: bus.readdata <= zero_ext(irq_mask);
                default:   bus.readdata <= zero_ext(edge_capture);
            endcase
            if (wr_en) begin
                case (bus.address)
                    ADDR_DATA: out_port <= wr_bits;
                    ADDR_DIR:  out_oe   <= wr_bits;
                    ADDR_MASK: irq_mask <= wr_bits;
                    default:   ;
                endcase
            end
            edge_capture <= capture_next;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule
